// File: rtl/box_readback_fb_if.sv
// Plot-stream sink and box readback bus.
// Master drives plots and readback requests; slave is the framebuffer.
interface box_readback_fb_if;
   logic [7:0] iX;
   logic [6:0] iY;
   logic [2:0] iColour;
   logic       iPlot;
   logic       iClear;
   logic       iRdLoad;
   logic [7:0] iRdX;
   logic [6:0] iRdY;
   logic       iRdReady;
   logic       oRdValid;
   logic [7:0] oRdX;
   logic [6:0] oRdY;
   logic [2:0] oRdColour;
   logic       oRdDone;
   logic       oBusy;
   logic [7:0] oDropCount;

   modport master (
      output iX, iY, iColour, iPlot, iClear,
      output iRdLoad, iRdX, iRdY, iRdReady,
      input  oRdValid, oRdX, oRdY, oRdColour,
      input  oRdDone, oBusy, oDropCount
   );

   modport slave (
      input  iX, iY, iColour, iPlot, iClear,
      input  iRdLoad, iRdX, iRdY, iRdReady,
      output oRdValid, oRdX, oRdY, oRdColour,
      output oRdDone, oBusy, oDropCount
   );
endinterface

// File: rtl/box_readback_fb.sv
// 160x120x3 framebuffer with plot writes, full clear and
// 4x4 box readback streamed in plotter pixel order.
module box_readback_fb #(
   parameter int X_SCREEN_PIXELS = 160,
   parameter int Y_SCREEN_PIXELS = 120
) (
   input logic               iClock,
   input logic               iResetn,
   box_readback_fb_if.slave  bus
);

   localparam int          DEPTH = X_SCREEN_PIXELS * Y_SCREEN_PIXELS;
   localparam logic [7:0]  X_LIM = 8'(X_SCREEN_PIXELS);
   localparam logic [6:0]  Y_LIM = 7'(Y_SCREEN_PIXELS);
   localparam logic [14:0] X_W   = 15'(X_SCREEN_PIXELS);
   localparam logic [14:0] LAST  = 15'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      RD_ADDR,
      RD_OUT
   } state_t;

   state_t      state;
   logic [14:0] clr_addr;
   logic [7:0]  org_x;
   logic [6:0]  org_y;
   logic [3:0]  c;

   logic        rd_valid;
   logic        rd_done;
   logic        busy;
   logic        rd_oor;
   logic [7:0]  rd_x;
   logic [6:0]  rd_y;
   logic [2:0]  rd_data;
   logic [7:0]  drop_cnt;

   logic [2:0]  mem [DEPTH];

   function automatic logic [14:0] addr_of(
      input logic [7:0] x,
      input logic [6:0] y
   );
      return 15'(y) * X_W + 15'(x);
   endfunction

   logic        plot_in;
   logic [14:0] plot_addr;
   logic [7:0]  pix_x;
   logic [6:0]  pix_y;
   logic        pix_in;
   logic        drop_evt;

   assign plot_in   = (bus.iX < X_LIM) && (bus.iY < Y_LIM);
   assign plot_addr = addr_of(bus.iX, bus.iY);
   assign pix_x     = org_x + {6'd0, c[1:0]};
   assign pix_y     = org_y + {5'd0, c[3:2]};
   assign pix_in    = (pix_x < X_LIM) && (pix_y < Y_LIM);
   assign drop_evt  = bus.iPlot && ((state == CLEAR) || !plot_in);

   // Single write port shared between the clear sweep and plots
   logic        we;
   logic [14:0] waddr;
   logic [2:0]  wdata;
   logic        re;
   logic [14:0] raddr;

   always_comb begin
      we    = 1'b0;
      waddr = plot_addr;
      wdata = bus.iColour;
      if (!iResetn) begin
         we = 1'b0;
      end else if (state == CLEAR) begin
         we    = 1'b1;
         waddr = clr_addr;
         wdata = 3'd0;
      end else begin
         we = bus.iPlot && plot_in;
      end
   end

   assign re    = iResetn && (state == RD_ADDR) && pix_in;
   assign raddr = addr_of(pix_x, pix_y);

   // Read-before-write: same-edge write to raddr returns the old value
   always_ff @(posedge iClock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rd_data <= mem[raddr];
      end
   end

   always_ff @(posedge iClock) begin
      if (!iResetn) begin
         drop_cnt <= 8'd0;
      end else if (drop_evt && (drop_cnt != 8'hFF)) begin
         drop_cnt <= drop_cnt + 8'd1;
      end
   end

   always_ff @(posedge iClock) begin
      if (!iResetn) begin
         state    <= IDLE;
         clr_addr <= 15'd0;
         org_x    <= 8'd0;
         org_y    <= 7'd0;
         c        <= 4'd0;
         rd_valid <= 1'b0;
         rd_done  <= 1'b0;
         busy     <= 1'b0;
         rd_oor   <= 1'b0;
         rd_x     <= 8'd0;
         rd_y     <= 7'd0;
      end else begin
         rd_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.iClear) begin
                  state    <= CLEAR;
                  clr_addr <= 15'd0;
                  busy     <= 1'b1;
               end else if (bus.iRdLoad) begin
                  state <= RD_ADDR;
                  org_x <= bus.iRdX;
                  org_y <= bus.iRdY;
                  c     <= 4'd0;
                  busy  <= 1'b1;
               end
            end
            CLEAR: begin
               clr_addr <= clr_addr + 15'd1;
               if (clr_addr == LAST) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            RD_ADDR: begin
               rd_x     <= pix_x;
               rd_y     <= pix_y;
               rd_oor   <= !pix_in;
               rd_valid <= 1'b1;
               state    <= RD_OUT;
            end
            RD_OUT: begin
               if (bus.iRdReady) begin
                  rd_valid <= 1'b0;
                  if (c == 4'd15) begin
                     rd_done <= 1'b1;
                     busy    <= 1'b0;
                     state   <= IDLE;
                  end else begin
                     c     <= c + 4'd1;
                     state <= RD_ADDR;
                  end
               end
            end
         endcase
      end
   end

   assign bus.oRdValid   = rd_valid;
   assign bus.oRdX       = rd_x;
   assign bus.oRdY       = rd_y;
   assign bus.oRdColour  = (rd_valid && !rd_oor) ? rd_data : 3'd0;
   assign bus.oRdDone    = rd_done;
   assign bus.oBusy      = busy;
   assign bus.oDropCount = drop_cnt;

endmodule
